// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, bit-period helper and frame-length constants.
// Used by both the transmitter and the receiver.
package uart_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_START = 3'd1;
  localparam state_t ST_DATA  = 3'd2;
  localparam state_t ST_STOP  = 3'd3;
  localparam state_t ST_BREAK = 3'd4;

  localparam int unsigned START_BITS = 1;

  function automatic int unsigned cycles_per_bit(input int unsigned clk_hz,
                                                 input int unsigned bit_rate);
    return clk_hz / bit_rate;
  endfunction

  function automatic int unsigned frame_bits(input int unsigned payload_bits,
                                             input int unsigned stop_bits);
    return START_BITS + payload_bits + stop_bits;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period down-counter: load restarts a CPB-cycle period, tick marks its last cycle.
module uart_bit_timer #(
  parameter int unsigned CPB = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic tick
);

  localparam int unsigned W = (CPB > 1) ? $clog2(CPB) : 1;

  logic [W-1:0] count_q, count_d;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    count_d = count_q;
    if (load) begin
      count_d = W'(CPB - 1);
    end else if (count_q != '0) begin
      count_d = count_q - W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tick = (count_q == '0);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 8N1-style frames from a valid/ready byte interface, plus line BREAK generation.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned BIT_RATE     = 9600,
  parameter int unsigned CLK_HZ       = 50000000,
  parameter int unsigned PAYLOAD_BITS = 8,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    uart_tx_en,
  input  logic                    uart_tx_valid,
  input  logic [PAYLOAD_BITS-1:0] uart_tx_data,
  output logic                    uart_tx_ready,
  input  logic                    uart_tx_break,
  output logic                    uart_tx_busy,
  output logic                    uart_txd
);

  localparam int unsigned CPB        = cycles_per_bit(CLK_HZ, BIT_RATE);
  localparam int unsigned FRAME_BITS = frame_bits(PAYLOAD_BITS, STOP_BITS);
  // Index also counts bit periods of a BREAK, so it must cover the whole frame.
  localparam int unsigned IDX_W_DATA  = $clog2(PAYLOAD_BITS + 1);
  localparam int unsigned IDX_W_FRAME = $clog2(FRAME_BITS);
  localparam int unsigned IDX_W = (IDX_W_DATA > IDX_W_FRAME) ? IDX_W_DATA : IDX_W_FRAME;

  localparam logic [IDX_W-1:0] LAST_DATA  = IDX_W'(PAYLOAD_BITS - 1);
  localparam logic [IDX_W-1:0] LAST_STOP  = IDX_W'(STOP_BITS - 1);
  localparam logic [IDX_W-1:0] LAST_BREAK = IDX_W'(FRAME_BITS - 1);

  state_t                  state_q, state_d;
  logic [PAYLOAD_BITS-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    txd_q, txd_d;
  logic                    busy_q, busy_d;
  logic                    load;
  logic                    tick;
  logic                    accept;
  logic                    start_break;

  uart_bit_timer #(.CPB(CPB)) u_bit_timer (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .tick (tick)
  );

  assign uart_tx_ready = !busy_q && uart_tx_en && !uart_tx_break;
  assign accept        = uart_tx_valid && uart_tx_ready;
  assign start_break   = uart_tx_break && uart_tx_en && !busy_q;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    load    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_break) begin
          state_d = ST_BREAK;
          idx_d   = '0;
          load    = 1'b1;
        end else if (accept) begin
          state_d = ST_START;
          shift_d = uart_tx_data;
          load    = 1'b1;
        end
      end
      ST_START: begin
        if (tick) begin
          state_d = ST_DATA;
          idx_d   = '0;
          load    = 1'b1;
        end
      end
      ST_DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          load    = 1'b1;
          if (idx_q == LAST_DATA) begin
            state_d = ST_STOP;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (idx_q == LAST_STOP) begin
            state_d = ST_IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
            load  = 1'b1;
          end
        end
      end
      ST_BREAK: begin
        if (tick) begin
          load = 1'b1;
          if (idx_q == LAST_BREAK) begin
            state_d = ST_STOP;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Line level is derived from the next state so it changes on the same edge as the FSM.
  always_comb begin
    unique case (state_d)
      ST_START, ST_BREAK: txd_d = 1'b0;
      ST_DATA:            txd_d = shift_d[0];
      default:            txd_d = 1'b1;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
    end
  end

  assign uart_tx_busy = busy_q;
  assign uart_txd     = txd_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx at CPB=16: frames decoded from the line against expected bit patterns.
module tb_uart_tx;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en1 = 1'b1, valid1 = 1'b0, brk1 = 1'b0;
  logic [7:0] data1 = '0;
  logic       ready1, busy1, txd1;
  logic       en2 = 1'b1, valid2 = 1'b0, brk2 = 1'b0;
  logic [7:0] data2 = '0;
  logic       ready2, busy2, txd2;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int acc_cyc[$];
  logic [7:0] acc_data[$];

  always #5 clk = ~clk;

  uart_tx #(.BIT_RATE(100000), .CLK_HZ(1600000), .PAYLOAD_BITS(8), .STOP_BITS(1)) dut (
    .clk(clk), .rst(rst), .uart_tx_en(en1), .uart_tx_valid(valid1), .uart_tx_data(data1),
    .uart_tx_ready(ready1), .uart_tx_break(brk1), .uart_tx_busy(busy1), .uart_txd(txd1)
  );

  uart_tx #(.BIT_RATE(100000), .CLK_HZ(1600000), .PAYLOAD_BITS(8), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .uart_tx_en(en2), .uart_tx_valid(valid2), .uart_tx_data(data2),
    .uart_tx_ready(ready2), .uart_tx_break(brk2), .uart_tx_busy(busy2), .uart_txd(txd2)
  );

  // Records every accept on the STOP_BITS=1 instance: cycle number and captured byte.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (valid1 && ready1) begin
      acc_cyc.push_back(cyc);
      acc_data.push_back(data1);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected line levels, one per bit period: start 0, data LSB first, then stop ones.
  function automatic logic [15:0] exp_frame(input logic [7:0] d, input int stops);
    int v;
    v = int'(d) * 2;
    for (int s = 0; s < stops; s++) v += 1 << (9 + s);
    return v[15:0];
  endfunction

  task automatic capture(input int sel, input int nbits, output logic [15:0] bits,
                         output int glitches, output int busy_n, output logic first);
    logic line, lvl, b;
    bits = '0; glitches = 0; busy_n = 0; first = 1'b1; lvl = 1'b1;
    for (int k = 0; k <= nbits * CPB; k++) begin
      @(negedge clk);
      line = (sel == 0) ? txd1 : txd2;
      b    = (sel == 0) ? busy1 : busy2;
      if (b) busy_n++;
      if (k == 0) first = line;
      if (k < nbits * CPB) begin
        if (k % CPB == 0) lvl = line;
        else if (line !== lvl) glitches++;
        if (k % CPB == CPB / 2) bits[k / CPB] = line;
      end
    end
  endtask

  task automatic check_frame(input string tag, input int sel, input int nbits,
                             input logic [15:0] exp_bits);
    logic [15:0] bits;
    int glitches, busy_n;
    logic first;
    capture(sel, nbits, bits, glitches, busy_n, first);
    check({tag, "_start"}, first, 1'b0);
    check({tag, "_bits"}, bits, exp_bits);
    check({tag, "_glitch"}, glitches, 0);
    check({tag, "_busy"}, busy_n, nbits * CPB);
  endtask

  // Offers a byte and returns just after the accepting edge.
  task automatic accept(input int sel, input logic [7:0] d, input bit hold);
    @(negedge clk);
    if (sel == 0) begin data1 = d; valid1 = 1'b1; end
    else begin data2 = d; valid2 = 1'b1; end
    for (int i = 0; i < 400; i++) begin
      if ((sel == 0) ? ready1 : ready2) begin
        @(posedge clk);
        #1;
        if (!hold) begin valid1 = 1'b0; valid2 = 1'b0; end
        return;
      end
      @(negedge clk);
    end
    check("accept_timeout", 1, 0);
    valid1 = 1'b0;
    valid2 = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    int n_acc;

    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_txd", txd1, 1'b1);
    check("rst_busy", busy1, 1'b0);
    check("rst_ready", ready1, 1'b1);
    check("rst_txd2", txd2, 1'b1);

    accept(0, 8'h55, 0);
    check("acc_55", acc_data[$], 8'h55);
    check_frame("f55", 0, 10, exp_frame(8'h55, 1));

    // Back-to-back with valid held high.
    acc_cyc.delete();
    acc_data.delete();
    accept(0, 8'hA3, 1);
    data1 = 8'h0F;
    check_frame("b2b_a3", 0, 10, exp_frame(8'hA3, 1));
    fork
      check_frame("b2b_0f", 0, 10, exp_frame(8'h0F, 1));
      begin @(posedge clk); #1 valid1 = 1'b0; end
    join
    check("b2b_count", acc_cyc.size(), 2);
    if (acc_cyc.size() >= 2) begin
      check("b2b_period", acc_cyc[1] - acc_cyc[0], 10 * CPB + 1);
      check("b2b_data1", acc_data[1], 8'h0F);
    end

    // Break wins over a simultaneous valid byte.
    n_acc = acc_cyc.size();
    @(negedge clk);
    valid1 = 1'b1; data1 = 8'h12; brk1 = 1'b1;
    #1 check("brk_ready", ready1, 1'b0);
    @(posedge clk);
    #1 brk1 = 1'b0; valid1 = 1'b0;
    check_frame("brk", 0, 11, 16'h0400);
    check("brk_no_accept", acc_cyc.size(), n_acc);
    repeat (20) @(negedge clk);
    check("brk_idle", {busy1, txd1}, 2'b01);

    // Randomised bytes; the data bus is scrambled right after each accept.
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      d = 8'($urandom);
      accept(0, d, 0);
      data1 = ~d;
      check("rnd_acc", acc_data[$], d);
      check_frame("rnd", 0, 10, exp_frame(d, 1));
    end

    // Enable dropped at bit 3: frame completes, then no acceptance.
    accept(0, 8'hC4, 0);
    fork
      check_frame("en", 0, 10, exp_frame(8'hC4, 1));
      begin repeat (4 * CPB + 4) @(negedge clk); en1 = 1'b0; end
    join
    check("en_ready_off", ready1, 1'b0);
    n_acc = acc_cyc.size();
    valid1 = 1'b1;
    repeat (20) @(negedge clk);
    check("en_no_accept", {busy1, 6'(acc_cyc.size() - n_acc)}, 7'd0);
    valid1 = 1'b0;
    en1 = 1'b1;
    #1 check("en_ready_on", ready1, 1'b1);

    // Asynchronous reset at bit 5.
    accept(0, 8'h00, 0);
    repeat (6 * CPB + 4) @(negedge clk);
    check("pre_rst_txd", txd1, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("arst_txd", txd1, 1'b1);
    check("arst_busy", busy1, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    accept(0, 8'h5A, 0);
    check_frame("post_rst", 0, 10, exp_frame(8'h5A, 1));

    // Two stop bits.
    accept(1, 8'hFF, 0);
    check_frame("stop2", 1, 11, exp_frame(8'hFF, 2));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
